readout_pulse_gen: RTL and testbench

// - Transmit side of the qubit readout chain: on fire, emits one shaped, IQ-modulated readout pulse to the
//   DAC at 5 samples/clk (500 MS/s on clk100) and pulses rx_trigger to arm the receive timing/sampler path.
// - Carrier phase law matches the receive demodulator: lane phase = (n*demod_freq) mod 50, 10 MHz steps.

---
 rtl/readout_pkg.sv | 24 ++
 rtl/iq_phase_lut.sv | 69 ++++++
 rtl/readout_pulse_gen.sv | 169 ++++++++++++++++
 tb/tb_readout_pulse_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared types, constants and phase/scale helpers for the readout transmit path
package readout_pkg;
    localparam int LANES     = 5;
    localparam int PHASE_MOD = 50;

    typedef logic signed [15:0] sample_t;
    typedef sample_t [LANES-1:0] lanes_t;
    typedef enum logic [1:0] {IDLE, RISE, FLAT, FALL} tx_state_t;

    function automatic logic [5:0] wrap_phase(input logic [6:0] x);
        return (x >= 7'(PHASE_MOD)) ? 6'(x - 7'(PHASE_MOD)) : x[5:0];
    endfunction

    // Q1.15 rescale truncating toward zero, so +/- full scale stay symmetric.
    function automatic sample_t scale_q15(input logic signed [31:0] p);
        logic signed [31:0] t;
        t = (p < 0) ? ((p + 32'sd32767) >>> 15) : (p >>> 15);
        if (t > 32'sd32767)
            return 16'sh7fff;
        if (t < -32'sd32768)
            return 16'sh8000;
        return t[15:0];
    endfunction
endpackage

// File: rtl/iq_phase_lut.sv
// rtl/iq_phase_lut.sv - 50-entry registered cos/sin ROM, Q1.15, one clock latency
module iq_phase_lut
    import readout_pkg::*;
(
    input  logic       clk100,
    input  logic       reset_n,
    input  logic [5:0] phase,
    output sample_t    cos_val,
    output sample_t    sin_val
);
    // Quarter-wave table in 3.6 degree steps (half a phase step), so both cos
    // and the 90-degree-shifted sin fall on integer indices.
    function automatic sample_t quarter(input logic [6:0] m);
        case (m)
            7'd0:  return 16'sd32767;
            7'd1:  return 16'sd32702;
            7'd2:  return 16'sd32509;
            7'd3:  return 16'sd32187;
            7'd4:  return 16'sd31738;
            7'd5:  return 16'sd31163;
            7'd6:  return 16'sd30466;
            7'd7:  return 16'sd29648;
            7'd8:  return 16'sd28714;
            7'd9:  return 16'sd27666;
            7'd10: return 16'sd26509;
            7'd11: return 16'sd25247;
            7'd12: return 16'sd23886;
            7'd13: return 16'sd22431;
            7'd14: return 16'sd20886;
            7'd15: return 16'sd19260;
            7'd16: return 16'sd17557;
            7'd17: return 16'sd15786;
            7'd18: return 16'sd13952;
            7'd19: return 16'sd12062;
            7'd20: return 16'sd10126;
            7'd21: return 16'sd8149;
            7'd22: return 16'sd6140;
            7'd23: return 16'sd4107;
            7'd24: return 16'sd2057;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic sample_t cos_half(input logic [6:0] a);
        logic [6:0] r;
        r = (a > 7'd50) ? 7'd100 - a : a;
        return (r > 7'd25) ? -quarter(7'd50 - r) : quarter(r);
    endfunction

    logic [6:0] a_cos;
    logic [6:0] a_sin;
    logic [7:0] a_shift;

    always_comb begin
        a_cos   = {phase, 1'b0};
        a_shift = {1'b0, a_cos} + 8'd75;
        a_sin   = (a_shift >= 8'd100) ? 7'(a_shift - 8'd100) : a_shift[6:0];
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            cos_val <= '0;
            sin_val <= '0;
        end else begin
            cos_val <= cos_half(a_cos);
            sin_val <= cos_half(a_sin);
        end
    end
endmodule

// File: rtl/readout_pulse_gen.sv
// rtl/readout_pulse_gen.sv - shaped IQ readout pulse generator, 5 samples/clk, with rx trigger
module readout_pulse_gen
    import readout_pkg::*;
#(
    parameter int RAMP_SHIFT = 3
) (
    input  logic        clk100,
    input  logic        reset_n,
    input  logic        fire,
    input  logic [3:0]  demod_freq,
    input  logic [10:0] pulse_length,
    input  logic [14:0] amplitude,
    output lanes_t      dac_i,
    output lanes_t      dac_q,
    output logic        dac_valid,
    output logic        rx_trigger,
    output logic        busy,
    output logic        done,
    output logic        len_err
);
    localparam int          RAMP_CLKS = 2**RAMP_SHIFT;
    localparam logic [10:0] MIN_LEN   = 11'(2*RAMP_CLKS);

    tx_state_t   state;
    logic [10:0] cnt;
    logic [10:0] flat_len;
    logic [3:0]  freq_q;
    logic [14:0] amp_q;
    logic [14:0] env_q;
    logic [14:0] env_d2;
    logic [5:0]  inc_q;
    logic [5:0]  b_q;
    logic        s1_valid;
    logic        s2_valid;
    logic [14:0] step;
    logic [14:0] env_dec;
    logic [6:0]  inc_raw;
    logic [6:0]  b_sum;
    sample_t     cos_lut [LANES];
    sample_t     sin_lut [LANES];

    assign step    = amp_q >> RAMP_SHIFT;
    assign env_dec = (env_q >= step) ? env_q - step : '0;
    assign inc_raw = 7'(demod_freq) * 7'd5;
    assign b_sum   = {1'b0, b_q} + {1'b0, inc_q};

    // Stage 1: envelope and base phase for the sample being generated this clock.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            flat_len <= '0;
            freq_q   <= '0;
            amp_q    <= '0;
            env_q    <= '0;
            inc_q    <= '0;
            b_q      <= '0;
            s1_valid <= 1'b0;
            busy     <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (done)
                busy <= 1'b0;
            case (state)
                IDLE: begin
                    s1_valid <= 1'b0;
                    if (fire && !busy) begin
                        if (pulse_length < MIN_LEN) begin
                            len_err <= 1'b1;
                        end else begin
                            state    <= RISE;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            freq_q   <= demod_freq;
                            amp_q    <= amplitude;
                            flat_len <= pulse_length - MIN_LEN;
                            inc_q    <= wrap_phase(inc_raw);
                            env_q    <= '0;
                            b_q      <= '0;
                            s1_valid <= 1'b1;
                        end
                    end
                end
                RISE: begin
                    b_q <= wrap_phase(b_sum);
                    if (cnt == 11'(RAMP_CLKS-1)) begin
                        cnt <= '0;
                        if (flat_len == '0) begin
                            state <= FALL;
                            env_q <= env_dec;
                        end else begin
                            state <= FLAT;
                            env_q <= amp_q;
                        end
                    end else begin
                        cnt   <= cnt + 11'd1;
                        env_q <= env_q + step;
                    end
                end
                FLAT: begin
                    b_q <= wrap_phase(b_sum);
                    if (cnt == flat_len - 11'd1) begin
                        state <= FALL;
                        cnt   <= '0;
                        env_q <= env_dec;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                FALL: begin
                    b_q <= wrap_phase(b_sum);
                    if (cnt == 11'(RAMP_CLKS-1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        s1_valid <= 1'b0;
                    end else begin
                        cnt   <= cnt + 11'd1;
                        env_q <= env_dec;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [6:0] lane_sum;
        logic [5:0] lane_phase;
        assign lane_sum   = {1'b0, b_q} + 7'(k) * {3'b0, freq_q};
        assign lane_phase = wrap_phase({1'b0, wrap_phase(lane_sum)});

        iq_phase_lut u_lut (
            .clk100  (clk100),
            .reset_n (reset_n),
            .phase   (lane_phase),
            .cos_val (cos_lut[k]),
            .sin_val (sin_lut[k])
        );
    end

    // Stages 2 and 3: align envelope with the LUT output, then scale into the DAC registers.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            env_d2     <= '0;
            dac_valid  <= 1'b0;
            rx_trigger <= 1'b0;
            done       <= 1'b0;
            dac_i      <= '0;
            dac_q      <= '0;
        end else begin
            s2_valid   <= s1_valid;
            env_d2     <= env_q;
            dac_valid  <= s2_valid;
            rx_trigger <= s2_valid & ~dac_valid;
            done       <= dac_valid & ~s2_valid;
            for (int k = 0; k < LANES; k++) begin
                if (s2_valid) begin
                    dac_i[k] <= scale_q15($signed({17'b0, env_d2}) * 32'(cos_lut[k]));
                    dac_q[k] <= scale_q15(-($signed({17'b0, env_d2}) * 32'(sin_lut[k])));
                end else begin
                    dac_i[k] <= '0;
                    dac_q[k] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_readout_pulse_gen.sv
// tb/tb_readout_pulse_gen.sv - self-checking bench for readout_pulse_gen against an arithmetic pulse model
module tb_readout_pulse_gen;
    import readout_pkg::*;

    localparam real PI = 3.14159265358979;

    logic        clk100 = 1'b0;
    logic        reset_n;
    logic        fire;
    logic [3:0]  demod_freq;
    logic [10:0] pulse_length;
    logic [14:0] amplitude;
    lanes_t      dac_i;
    lanes_t      dac_q;
    logic        dac_valid;
    logic        rx_trigger;
    logic        busy;
    logic        done;
    logic        len_err;

    int checks   = 0;
    int failures = 0;

    readout_pulse_gen #(.RAMP_SHIFT(3)) dut (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .fire         (fire),
        .demod_freq   (demod_freq),
        .pulse_length (pulse_length),
        .amplitude    (amplitude),
        .dac_i        (dac_i),
        .dac_q        (dac_q),
        .dac_valid    (dac_valid),
        .rx_trigger   (rx_trigger),
        .busy         (busy),
        .done         (done),
        .len_err      (len_err)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input real exp);
        checks++;
        assert ((obs - exp) <= 2.0 && (exp - obs) <= 2.0) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0.2f", tag, obs, exp);
        end
    endtask

    // Envelope of sample t: linear ramp up over 8 clocks, flat, then 8 decrements floored at 0.
    function automatic int exp_env(input int t, input int len, input int amp);
        int stp, e0, e;
        stp = amp >> 3;
        if (t < 8)
            return t * stp;
        if (t < len - 8)
            return amp;
        e0 = (len == 16) ? 7 * stp : amp;
        e  = e0 - (t - (len - 8) + 1) * stp;
        return (e < 0) ? 0 : e;
    endfunction

    task automatic run_pulse(input int f, input int len, input int amp, input bit refire);
        int  t, e, p;
        real ang, ei, eq;
        @(negedge clk100);
        fire = 1'b1; demod_freq = 4'(f); pulse_length = 11'(len); amplitude = 15'(amp);
        @(negedge clk100);
        fire = 1'b0;
        for (int c = 1; c <= len + 5; c++) begin
            check($sformatf("busy c=%0d", c), int'(busy), int'(c <= len + 3));
            check($sformatf("dac_valid c=%0d", c), int'(dac_valid), int'(c >= 3 && c <= len + 2));
            check($sformatf("rx_trigger c=%0d", c), int'(rx_trigger), int'(c == 3));
            check($sformatf("done c=%0d", c), int'(done), int'(c == len + 3));
            if (c >= 3 && c <= len + 2) begin
                t = c - 3;
                e = exp_env(t, len, amp);
                for (int k = 0; k < LANES; k++) begin
                    p   = (t * 5 * f + k * f) % 50;
                    ang = 2.0 * PI * p / 50.0;
                    ei  = e * 32767.0 * $cos(ang) / 32768.0;
                    eq  = -e * 32767.0 * $sin(ang) / 32768.0;
                    check_near($sformatf("dac_i t=%0d k=%0d", t, k), int'(dac_i[k]), ei);
                    check_near($sformatf("dac_q t=%0d k=%0d", t, k), int'(dac_q[k]), eq);
                    if (e == 0) begin
                        check($sformatf("zero_env_i t=%0d k=%0d", t, k), int'(dac_i[k]), 0);
                        check($sformatf("zero_env_q t=%0d k=%0d", t, k), int'(dac_q[k]), 0);
                    end else if (e == 32767 && (p == 0 || p == 25)) begin
                        check($sformatf("peak_i t=%0d k=%0d", t, k), int'(dac_i[k]), (p == 0) ? 32766 : -32766);
                        check($sformatf("peak_q t=%0d k=%0d", t, k), int'(dac_q[k]), 0);
                    end
                end
            end else begin
                check($sformatf("idle_i c=%0d", c), int'(dac_i == '0), 1);
                check($sformatf("idle_q c=%0d", c), int'(dac_q == '0), 1);
            end
            if (refire && c == 5) begin
                fire = 1'b1; demod_freq = 4'd9; pulse_length = 11'(len + 7); amplitude = 15'd999;
            end else begin
                fire = 1'b0;
            end
            @(negedge clk100);
        end
    endtask

    task automatic short_fire(input int len);
        @(negedge clk100);
        fire = 1'b1; demod_freq = 4'd3; pulse_length = 11'(len); amplitude = 15'd1000;
        @(negedge clk100);
        fire = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("len_err L=%0d c=%0d", len, c), int'(len_err), int'(c == 1));
            check($sformatf("short busy c=%0d", c), int'(busy), 0);
            check($sformatf("short dac_valid c=%0d", c), int'(dac_valid), 0);
            check($sformatf("short rx_trigger c=%0d", c), int'(rx_trigger), 0);
            @(negedge clk100);
        end
    endtask

    initial begin
        reset_n = 1'b0; fire = 1'b0; demod_freq = '0; pulse_length = '0; amplitude = '0;
        repeat (3) @(negedge clk100);
        check("reset dac_valid", int'(dac_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset len_err", int'(len_err), 0);
        check("reset rx_trigger", int'(rx_trigger), 0);
        check("reset dac_i", int'(dac_i == '0), 1);
        check("reset dac_q", int'(dac_q == '0), 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk100);

        run_pulse(5, 16, 32767, 1'b0);
        short_fire(10);
        short_fire(15);
        run_pulse(5, 20, 32767, 1'b0);
        run_pulse(7, 24, int'($urandom_range(32767, 1000)), 1'b1);

        // Reset asserted between clock edges while the pulse is in its flat section.
        @(negedge clk100);
        fire = 1'b1; demod_freq = 4'd3; pulse_length = 11'd30; amplitude = 15'd20000;
        @(negedge clk100);
        fire = 1'b0;
        repeat (11) @(negedge clk100);
        check("pre_reset dac_valid", int'(dac_valid), 1);
        check("pre_reset busy", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async dac_valid", int'(dac_valid), 0);
        check("async busy", int'(busy), 0);
        check("async dac_i", int'(dac_i == '0), 1);
        check("async dac_q", int'(dac_q == '0), 1);
        @(negedge clk100);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk100);
            check($sformatf("post_reset done c=%0d", c), int'(done), 0);
            check($sformatf("post_reset dac_valid c=%0d", c), int'(dac_valid), 0);
        end
        run_pulse(4, 25, 12345, 1'b0);

        run_pulse(0, 18, int'($urandom_range(32767, 0)), 1'b0);
        for (int r = 0; r < 4; r++)
            run_pulse(int'($urandom_range(15, 0)), int'($urandom_range(40, 16)),
                      int'($urandom_range(32767, 0)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
